// File: rtl/recovunit_stream.sv
// Offset min-sum recovery unit: expands one compressed check-node row into
// Wc signed messages, streamed as Wc/P beats of P lanes.
module recovunit_stream #(
    parameter int Wc        = 32,
    parameter int Wcbits    = 5,
    parameter int W         = 10,
    parameter int P         = 8,
    parameter int NBEATS    = Wc / P,
    parameter int Bbits     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    parameter int ECOMPSIZE = 2 * (W - 1) + Wcbits + Wc
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ECOMPSIZE-1:0] Ecomp,
    input  logic [W-2:0]         offset,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P*W-1:0]       out_data,
    output logic [Bbits-1:0]     out_beat,
    output logic                 out_last,
    output logic                 dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and data holds while stalled.

    localparam int MIN2_LSB = Wc + Wcbits;
    localparam int MIN1_LSB = MIN2_LSB + W - 1;
    localparam logic [Bbits-1:0] LAST_BEAT = Bbits'(NBEATS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state;
    logic [Bbits-1:0]    beat;
    logic [W-2:0]        row_min1;
    logic [W-2:0]        row_min2;
    logic [Wcbits-1:0]   row_pos;
    logic [Wc-1:0]       row_sign;
    logic [W-2:0]        row_off;

    logic                at_last;
    logic                load;

    assign at_last   = (beat == LAST_BEAT);
    assign in_ready  = (state == IDLE) || (out_ready && at_last);
    assign load      = in_valid && in_ready;
    assign out_valid = (state == STREAM);
    assign out_beat  = beat;
    assign out_last  = (state == STREAM) && at_last;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat     <= '0;
            row_min1 <= '0;
            row_min2 <= '0;
            row_pos  <= '0;
            row_sign <= '0;
            row_off  <= '0;
        end else begin
            if (load) begin
                row_min1 <= Ecomp[MIN1_LSB +: W-1];
                row_min2 <= Ecomp[MIN2_LSB +: W-1];
                row_pos  <= Ecomp[Wc +: Wcbits];
                row_sign <= Ecomp[Wc-1:0];
                row_off  <= offset;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        beat  <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (!at_last) begin
                            beat <= beat + 1'b1;
                        end else begin
                            beat <= '0;
                            if (!in_valid) state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    // One-hot of the Min2 edge; a Pos beyond Wc-1 matches nothing.
    logic [Wc-1:0] pos_hit;
    always_comb begin
        pos_hit = '0;
        for (int k = 0; k < Wc; k++) begin
            pos_hit[k] = (row_pos == Wcbits'(k));
        end
    end

    logic [15:0]   shamt;
    logic [Wc-1:0] sign_sh;
    logic [Wc-1:0] hit_sh;

    assign shamt   = 16'(beat) * 16'(P);
    assign sign_sh = row_sign >> shamt;
    assign hit_sh  = pos_hit >> shamt;

    for (genvar j = 0; j < P; j++) begin : g_lane
        logic [W-2:0] mag;
        logic [W-2:0] mag_o;
        logic [W-1:0] val;

        assign mag   = hit_sh[j] ? row_min2 : row_min1;
        assign mag_o = (mag > row_off) ? (mag - row_off) : '0;
        // Negating a zero magnitude yields zero, so no negative zero appears.
        assign val   = sign_sh[j] ? (-{1'b0, mag_o}) : {1'b0, mag_o};
        assign out_data[j*W +: W] = (state == STREAM) ? val : '0;
    end

endmodule

// File: tb/tb_recovunit_stream.sv
// Directed bench for recovunit_stream: table of rows with hand-computed
// per-edge-class results, plus reset, backpressure and back-to-back sequences.
module tb_recovunit_stream;

  localparam int WC = 32;
  localparam int WCB = 5;
  localparam int W = 10;
  localparam int P = 8;
  localparam int NB = 4;
  localparam int BB = 2;
  localparam int ES = 2 * (W - 1) + WCB + WC;
  localparam int EW = 1 + BB + P * W;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [ES-1:0] ecomp;
  logic [W-2:0] offset;
  logic out_valid;
  logic out_ready;
  logic [P*W-1:0] out_data;
  logic [BB-1:0] out_beat;
  logic out_last;
  logic dbg_state;

  recovunit_stream dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Ecomp(ecomp),
    .offset(offset),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_beat(out_beat),
    .out_last(out_last),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // m1p/m1n: Min1 edge with sign 0/1; m2p/m2n: the Pos edge with sign 0/1
  typedef struct {
    logic [W-2:0] min1;
    logic [W-2:0] min2;
    logic [WCB-1:0] pos;
    logic [WC-1:0] sign;
    logic [W-2:0] off;
    logic [W-1:0] m1p;
    logic [W-1:0] m1n;
    logic [W-1:0] m2p;
    logic [W-1:0] m2n;
  } vec_t;

  vec_t vecs[7];
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [P*W-1:0] exp_beat(input vec_t v, input int b);
    logic [P*W-1:0] r;
    logic [W-1:0] x;
    r = '0;
    for (int j = 0; j < P; j++) begin
      int k;
      k = b * P + j;
      if (k == int'(v.pos)) x = v.sign[k] ? v.m2n : v.m2p;
      else x = v.sign[k] ? v.m1n : v.m1p;
      r[j*W +: W] = x;
    end
    return r;
  endfunction

  // scoreboard / monitor
  logic stall_seen = 1'b0;
  logic [EW-1:0] stall_val;

  always @(negedge clk) begin
    if (!rst) begin
      stall_seen = 1'b0;
    end else begin
      if (out_valid && stall_seen) check("stall_hold", {out_last, out_beat, out_data}, stall_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_last, out_beat, out_data}, '1);
        end else begin
          check("beat", {out_last, out_beat, out_data}, exp_q.pop_front());
        end
      end
      stall_seen = out_valid && !out_ready;
      stall_val = {out_last, out_beat, out_data};
    end
  end

  // driver tasks (called at posedge + #1)
  task automatic load_row(input vec_t v);
    bit ok;
    ecomp = {v.min1, v.min2, v.pos, v.sign};
    offset = v.off;
    in_valid = 1'b1;
    for (int b = 0; b < NB; b++) begin
      logic [BB-1:0] bb;
      bb = BB'(b);
      exp_q.push_back({(b == NB - 1), bb, exp_beat(v, b)});
    end
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    ecomp = {$urandom, $urandom, $urandom};
    offset = W'($urandom) & 9'h1FF;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{9'd5,   9'd9,   5'd3,  32'h0000_0001, 9'd0,   10'h005, 10'h3FB, 10'h009, 10'h3F7};
    vecs[1] = '{9'd2,   9'd7,   5'd10, 32'hFFFF_FFFF, 9'd3,   10'h000, 10'h000, 10'h004, 10'h3FC};
    vecs[2] = '{9'd100, 9'd511, 5'd20, 32'hA5A5_A5A5, 9'd0,   10'h064, 10'h39C, 10'h1FF, 10'h201};
    vecs[3] = '{9'd20,  9'd40,  5'd0,  32'h0F0F_0F0F, 9'd20,  10'h000, 10'h000, 10'h014, 10'h3EC};
    vecs[4] = '{9'd3,   9'd6,   5'd17, 32'hFFFF_0000, 9'd100, 10'h000, 10'h000, 10'h000, 10'h000};
    vecs[5] = '{9'd0,   9'd511, 5'd5,  32'hFFFF_FFFF, 9'd1,   10'h000, 10'h000, 10'h1FE, 10'h202};
    vecs[6] = '{9'd12,  9'd30,  5'd31, 32'h8000_0001, 9'd2,   10'h00A, 10'h3F6, 10'h01C, 10'h3E4};

    // reset with random inputs
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ecomp = '0;
    offset = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      ecomp = {$urandom, $urandom, $urandom};
      offset = 9'($urandom);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_data", out_data, 0);
      check("rst_out_beat", out_beat, 0);
      check("rst_out_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);
      check("idle_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // basic row: beat timing, out_last and in_ready
    load_row(vecs[0]);
    scramble();
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      check("basic_valid", out_valid, 1);
      check("basic_beat", out_beat, b);
      check("basic_last", out_last, (b == NB - 1));
      check("basic_in_ready", in_ready, (b == NB - 1));
    end
    @(negedge clk);
    check("basic_done", out_valid, 0);
    @(posedge clk);
    #1;

    // table of rows
    for (int i = 0; i < 7; i++) begin
      load_row(vecs[i]);
      scramble();
      wait_drain();
    end

    // backpressure: out_ready 0,1,0,1,... beats held for two cycles
    out_ready = 1'b0;
    load_row(vecs[1]);
    scramble();
    for (int c = 0; c < 2 * NB; c++) begin
      out_ready = c[0];
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_beat", out_beat, c / 2);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_done", out_valid, 0);
    check("bp_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // back-to-back rows, second row with Pos=31
    load_row(vecs[0]);
    fork
      begin
        load_row(vecs[6]);
        scramble();
      end
      begin
        for (int i = 0; i < 2 * NB; i++) begin
          @(negedge clk);
          check("b2b_valid", out_valid, 1);
        end
        @(negedge clk);
        check("b2b_done", out_valid, 0);
      end
    join
    wait_drain();

    // reset in the middle of a row
    load_row(vecs[1]);
    scramble();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_beat", out_beat, 2);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_release_valid", out_valid, 0);
    @(posedge clk);
    #1;
    load_row(vecs[2]);
    scramble();
    @(negedge clk);
    check("mid_restart_beat", out_beat, 0);
    wait_drain();

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
